// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with a write-side FIFO.
// Frames are start bit, DATA_BITS data bits LSB first, optional even parity
// bit, and one stop bit; the FIFO is drained back-to-back with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit per frame).
//
// TX FSM states:
//   state     | meaning
//   ST_IDLE   | line idle high, waiting for a queued entry
//   ST_START  | start bit (line low) for CLK_DIV cycles
//   ST_DATA   | data bits, LSB first, CLK_DIV cycles each
//   ST_PARITY | even parity bit (only when UART_TX_PARITY_EN is defined)
//   ST_STOP   | stop bit (line high); pops the next entry straight into START

module uart_tx_fifo #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [DATA_BITS-1:0]              wr_data,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              overflow,
    output logic                              busy,
    output logic                              uart_tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int IDX_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 overflow_q, overflow_d;
    logic                 wr_accept;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // Transmitter state
    state_t               state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 busy_q;
    logic                 uart_tx_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    assign head = mem_q[rd_ptr_q];

    // Pop whenever the transmitter is ready for a new frame and data is waiting.
    always_comb begin
        pop = 1'b0;
        if (!empty_q) begin
            if (state_q == ST_IDLE) begin
                pop = 1'b1;
            end else if (state_q == ST_STOP && baud_q == '0) begin
                pop = 1'b1;
            end
        end
    end

    // Next-state for pointers, occupancy and flags; full is sampled pre-edge.
    always_comb begin
        wr_accept  = wr_en && !full_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr_en && full_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    // FIFO control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // TX FSM with registered line and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            uart_tx_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    uart_tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= head;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^head;
`endif
                        state_q   <= ST_START;
                        baud_q    <= BAUD_LOAD;
                        uart_tx_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_q == '0) begin
                        state_q   <= ST_DATA;
                        baud_q    <= BAUD_LOAD;
                        bit_idx_q <= '0;
                        uart_tx_q <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end else begin
                        baud_q <= baud_q - BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= BAUD_LOAD;
                        if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_q   <= ST_PARITY;
                            uart_tx_q <= parity_q;
`else
                            state_q   <= ST_STOP;
                            uart_tx_q <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            uart_tx_q <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q - BAUD_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_q == '0) begin
                        state_q   <= ST_STOP;
                        baud_q    <= BAUD_LOAD;
                        uart_tx_q <= 1'b1;
                    end else begin
                        baud_q <= baud_q - BAUD_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_q == '0) begin
                        if (pop) begin
                            shift_q   <= head;
`ifdef UART_TX_PARITY_EN
                            parity_q  <= ^head;
`endif
                            state_q   <= ST_START;
                            baud_q    <= BAUD_LOAD;
                            uart_tx_q <= 1'b0;
                        end else begin
                            state_q   <= ST_IDLE;
                            uart_tx_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q - BAUD_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    uart_tx_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign uart_tx  = uart_tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: queue-based frame model, line receiver and
// hand-computed checks for the directed scenarios.
module tb_uart_tx_fifo;

    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int FRAME = (DATA_BITS + 2 + NPAR) * CLK_DIV;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, busy, uart_tx;
    logic [2:0] count;

    uart_tx_fifo #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .busy    (busy),
        .uart_tx (uart_tx)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: a queue of pending bytes plus the position in the current frame.
    logic [7:0] mq[$];
    logic [7:0] m_sent[$];
    bit         m_active;
    int         m_t;
    logic [7:0] m_cur;
    logic       e_tx, e_busy, e_full, e_empty, e_ovf;
    int         e_count;

    logic [7:0] rx_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] b, input int t);
        int k;
        k = t / CLK_DIV;
        if (k == 0) return 1'b0;
        if (k <= DATA_BITS) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == DATA_BITS + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic void model_outputs();
        e_tx    = m_active ? line_bit(m_cur, m_t) : 1'b1;
        e_busy  = m_active;
        e_count = mq.size();
        e_full  = (mq.size() == FIFO_DEPTH);
        e_empty = (mq.size() == 0);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_active = 1'b0;
        m_t      = 0;
        m_cur    = 8'h00;
        e_ovf    = 1'b0;
        model_outputs();
    endfunction

    function automatic void model_step(input logic we, input logic [7:0] wd);
        bit full_pre, empty_pre, do_pop;
        full_pre  = (mq.size() == FIFO_DEPTH);
        empty_pre = (mq.size() == 0);
        do_pop    = 1'b0;
        if (!m_active) begin
            if (!empty_pre) do_pop = 1'b1;
        end else if (m_t == FRAME - 1) begin
            if (!empty_pre) do_pop = 1'b1;
            else m_active = 1'b0;
        end else begin
            m_t++;
        end
        if (do_pop) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_t      = 0;
            m_sent.push_back(m_cur);
        end
        e_ovf = we && full_pre;
        if (we && !full_pre) mq.push_back(wd);
        model_outputs();
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step(wr_en, wr_data);
        #1;
    endtask

    // Compare DUT outputs with the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_uart_tx",  uart_tx,  e_tx);
                check("cyc_busy",     busy,     e_busy);
                check("cyc_count",    count,    e_count);
                check("cyc_full",     full,     e_full);
                check("cyc_empty",    empty,    e_empty);
                check("cyc_overflow", overflow, e_ovf);
            end
        end
    end

    // Line receiver: samples mid-bit and collects decoded bytes.
    initial begin
        bit         rx_act;
        int         rx_cnt;
        int         k;
        logic [7:0] rx_b;
        rx_act = 1'b0;
        rx_cnt = 0;
        rx_b   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (chk_en && uart_tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                    rx_b   = 8'h00;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CLK_DIV == CLK_DIV / 2) begin
                    k = rx_cnt / CLK_DIV;
                    if (k == 0) check("rx_start", uart_tx, 1'b0);
                    if (k >= 1 && k <= DATA_BITS) rx_b[k-1] = uart_tx;
`ifdef UART_TX_PARITY_EN
                    if (k == DATA_BITS + 1) check("rx_parity", uart_tx, ^rx_b);
`endif
                    if (k == DATA_BITS + 1 + NPAR) check("rx_stop", uart_tx, 1'b1);
                end
                if (rx_cnt == FRAME - 1) begin
                    rx_q.push_back(rx_b);
                    rx_act = 1'b0;
                end
            end
        end
    end

    task automatic drain(input string nm, input int maxc);
        int c;
        c = 0;
        while ((busy !== 1'b0 || empty !== 1'b1) && c < maxc) begin
            tick();
            c++;
        end
        check({nm, "_idle_in_time"}, (c < maxc), 1'b1);
    endtask

    task automatic check_q(input string nm, input bq_t act, input bq_t exp);
        check({nm, "_len"}, act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++) begin
            check({nm, "_byte"}, act[i], exp[i]);
        end
    endtask

    task automatic clear_logs();
        rx_q.delete();
        m_sent.delete();
    endtask

    // Single byte from idle; pat lists the expected data-bit line levels in send order.
    task automatic single_byte(input string nm, input logic [7:0] b, input logic [0:7] pat,
                               input logic par);
        int   busy_cnt;
        int   k;
        logic exp;
        bq_t  e;
        drain({nm, "_pre"}, 400);
        clear_logs();
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
        check({nm, "_empty_after_wr"}, empty, 1'b0);
        check({nm, "_line_high_before_pop"}, uart_tx, 1'b1);
        tick();
        check({nm, "_line_low_after_pop"}, uart_tx, 1'b0);
        check({nm, "_count_after_pop"}, count, 3'd0);
        busy_cnt = 0;
        for (int i = 0; i < FRAME + 4; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (i % CLK_DIV == CLK_DIV / 2) begin
                k = i / CLK_DIV;
                if (k == 0) exp = 1'b0;
                else if (k <= 8) exp = pat[k-1];
`ifdef UART_TX_PARITY_EN
                else if (k == 9) exp = par;
`endif
                else exp = 1'b1;
                check({nm, "_line_bit"}, uart_tx, exp);
            end
            tick();
        end
        check({nm, "_busy_cycles"}, busy_cnt, FRAME);
        check({nm, "_empty_after"}, empty, 1'b1);
        e = '{b};
        check_q({nm, "_rx"}, rx_q, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   busy_cnt, ovf_cnt, c, sent;
        bit   seen;
        bq_t  e;

        model_reset();
        rst = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        // Single byte 0x4B: line 1,1,0,1,0,0,1,0; even parity 0.
        single_byte("single_4b", 8'h4B, 8'b11010010, 1'b0);
        // 0x07: line 1,1,1,0,0,0,0,0; even parity 1.
        single_byte("single_07", 8'h07, 8'b11100000, 1'b1);

        // Burst of six writes into a depth-4 FIFO.
        drain("burst_pre", 400);
        clear_logs();
        busy_cnt = 0;
        ovf_cnt  = 0;
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i + 1);
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (overflow === 1'b1) ovf_cnt++;
            if (i == 0) check("burst_busy_edge1", busy, 1'b0);
            if (i == 1) begin
                check("burst_pop_edge2_busy", busy, 1'b1);
                check("burst_pop_edge2_count", count, 3'd1);
            end
            if (i == 4) begin
                check("burst_count4", count, 3'd4);
                check("burst_full", full, 1'b1);
            end
            if (i == 5) check("burst_overflow", overflow, 1'b1);
        end
        wr_en = 1'b0;
        c = 0;
        while ((busy !== 1'b0 || empty !== 1'b1) && c < 400) begin
            tick();
            c++;
            if (busy === 1'b1) busy_cnt++;
            if (overflow === 1'b1) ovf_cnt++;
        end
        check("burst_idle_in_time", (c < 400), 1'b1);
        check("burst_busy_cycles", busy_cnt, 5 * FRAME);
        check("burst_ovf_pulses", ovf_cnt, 1);
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_q("burst_rx", rx_q, e);

        // Write while full in the same cycle the FSM pops.
        drain("fullpop_pre", 400);
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h11 + i);
            tick();
        end
        check("fullpop_full", full, 1'b1);
        wr_data = 8'hEE;
        seen = 1'b0;
        c = 0;
        while (!seen && c < 100) begin
            tick();
            c++;
            if (count === 3'd3) seen = 1'b1;
        end
        wr_en = 1'b0;
        check("fullpop_seen", seen, 1'b1);
        check("fullpop_overflow", overflow, 1'b1);
        check("fullpop_count", count, 3'd3);
        drain("fullpop", 400);
        e = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        check_q("fullpop_rx", rx_q, e);

        // Pointer wrap: stream ten bytes keeping occupancy at most three.
        drain("wrap_pre", 400);
        clear_logs();
        sent = 0;
        c = 0;
        while (sent < 10 && c < 3000) begin
            if (mq.size() < 3 && $urandom_range(0, 2) == 0) begin
                wr_en   = 1'b1;
                wr_data = 8'(8'hA0 + sent);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            c++;
        end
        wr_en = 1'b0;
        check("wrap_all_sent", sent, 10);
        drain("wrap", 800);
        e = '{};
        for (int i = 0; i < 10; i++) e.push_back(8'(8'hA0 + i));
        check_q("wrap_rx", rx_q, e);

        // Reset during DATA bit 3 with two entries queued.
        drain("rstmid_pre", 400);
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h31 + i);
            tick();
        end
        wr_en = 1'b0;
        c = 0;
        while (!(m_active && m_t == 4 * CLK_DIV + 1) && c < 200) begin
            tick();
            c++;
        end
        check("rstmid_reached", (c < 200), 1'b1);
        check("rstmid_pre_count", count, 3'd2);
        rst = 1'b1;
        model_reset();
        #1;
        check("rstmid_uart_tx", uart_tx, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_count", count, 3'd0);
        check("rstmid_empty", empty, 1'b1);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_logs();
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        drain("rstmid_post", 400);
        e = '{8'h55};
        check_q("rstmid_rx", rx_q, e);

        // Random traffic including overflow.
        drain("rand_pre", 400);
        clear_logs();
        for (int i = 0; i < 600; i++) begin
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        drain("rand", 1000);
        check_q("rand_rx", rx_q, m_sent);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
